// File: rtl/jtag_pkg.sv
// jtag_pkg: shared definitions for the JTAG TAP responder.
//   - tap_state_t : TAP controller state encodings (IEEE 1149.1 style)
//   - IR_WIDTH and the IDCODE / USER / BYPASS opcodes
//   - tap_next_state() : TAP controller transition on a TCK rise
//   - is_shift_state() : true for Shift-DR / Shift-IR
package jtag_pkg;

  localparam int IR_WIDTH = 5;

  localparam logic [IR_WIDTH-1:0] OP_IDCODE  = 5'h01;
  localparam logic [IR_WIDTH-1:0] OP_USER    = 5'h10;
  localparam logic [IR_WIDTH-1:0] OP_BYPASS  = 5'h1F;
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = 5'b00001;

  typedef enum logic [3:0] {
    TAP_EXIT2_DR   = 4'h0,
    TAP_EXIT1_DR   = 4'h1,
    TAP_SHIFT_DR   = 4'h2,
    TAP_PAUSE_DR   = 4'h3,
    TAP_SELECT_IR  = 4'h4,
    TAP_UPDATE_DR  = 4'h5,
    TAP_CAPTURE_DR = 4'h6,
    TAP_SELECT_DR  = 4'h7,
    TAP_EXIT2_IR   = 4'h8,
    TAP_EXIT1_IR   = 4'h9,
    TAP_SHIFT_IR   = 4'hA,
    TAP_PAUSE_IR   = 4'hB,
    TAP_IDLE       = 4'hC,
    TAP_UPDATE_IR  = 4'hD,
    TAP_CAPTURE_IR = 4'hE,
    TAP_RESET      = 4'hF
  } tap_state_t;

  function automatic tap_state_t tap_next_state(input tap_state_t cur, input logic tms);
    tap_state_t nxt;
    case (cur)
      TAP_RESET:      nxt = tms ? TAP_RESET     : TAP_IDLE;
      TAP_IDLE:       nxt = tms ? TAP_SELECT_DR : TAP_IDLE;
      TAP_SELECT_DR:  nxt = tms ? TAP_SELECT_IR : TAP_CAPTURE_DR;
      TAP_CAPTURE_DR: nxt = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_SHIFT_DR:   nxt = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_EXIT1_DR:   nxt = tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR:   nxt = tms ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
      TAP_EXIT2_DR:   nxt = tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
      TAP_UPDATE_DR:  nxt = tms ? TAP_SELECT_DR : TAP_IDLE;
      TAP_SELECT_IR:  nxt = tms ? TAP_RESET     : TAP_CAPTURE_IR;
      TAP_CAPTURE_IR: nxt = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_SHIFT_IR:   nxt = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_EXIT1_IR:   nxt = tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR:   nxt = tms ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
      TAP_EXIT2_IR:   nxt = tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
      TAP_UPDATE_IR:  nxt = tms ? TAP_SELECT_DR : TAP_IDLE;
      default:        nxt = TAP_RESET;
    endcase
    return nxt;
  endfunction

  function automatic logic is_shift_state(input tap_state_t s);
    return (s == TAP_SHIFT_DR) || (s == TAP_SHIFT_IR);
  endfunction

endpackage

// File: rtl/jtag_sync_edge.sv
// jtag_sync_edge: brings the asynchronous JTAG pins into the system clock
// domain and detects TCK edges.
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   tck, tms, tdi, trst_n   raw JTAG pins
//   tck_rise, tck_fall      one-cycle strobes on synchronized TCK edges
//   tms_sync, tdi_sync      synchronized TMS / TDI (aligned with the strobes)
//   trst_n_sync             synchronized active-low test reset
module jtag_sync_edge
  import jtag_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic tck,
  input  logic tms,
  input  logic tdi,
  input  logic trst_n,
  output logic tck_rise,
  output logic tck_fall,
  output logic tms_sync,
  output logic tdi_sync,
  output logic trst_n_sync
);

  // Bit order inside each stage: {trst_n, tdi, tms, tck}; idle pins are TCK=0, TMS=1, TDI=0, TRSTn=1.
  localparam logic [3:0] SYNC_RESET = 4'b1010;

  logic [3:0] sync_r [SYNC_STAGES];
  logic       tck_prev_r;

  // Synchronizer chain plus one extra TCK sample used for edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= SYNC_RESET;
      end
      tck_prev_r <= 1'b0;
    end else begin
      sync_r[0] <= {trst_n, tdi, tms, tck};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      tck_prev_r <= sync_r[SYNC_STAGES-1][0];
    end
  end

  assign tck_rise    =  sync_r[SYNC_STAGES-1][0] & ~tck_prev_r;
  assign tck_fall    = ~sync_r[SYNC_STAGES-1][0] &  tck_prev_r;
  assign tms_sync    =  sync_r[SYNC_STAGES-1][1];
  assign tdi_sync    =  sync_r[SYNC_STAGES-1][2];
  assign trst_n_sync =  sync_r[SYNC_STAGES-1][3];

endmodule

// File: rtl/jtag_tap_responder.sv
// jtag_tap_responder: JTAG TAP controller running entirely in the system
// clock domain, with IDCODE, USER and BYPASS data registers.
// Ports:
//   clock, reset                 system clock, synchronous active-high reset
//   io_jtag_TCK/TMS/TDI/TRSTn    JTAG pins, sampled as data
//   io_jtag_TDO, tdo_en          test data out and its enable (Shift states only)
//   user_capture_data            loaded into the USER DR on Capture-DR
//   user_update_valid/_data      one-cycle pulse and held data on USER Update-DR
//   tap_state                    current TAP controller state
module jtag_tap_responder
  import jtag_pkg::*;
#(
  parameter logic [31:0] IDCODE      = 32'h0000_0001,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_jtag_TCK,
  input  logic        io_jtag_TMS,
  input  logic        io_jtag_TDI,
  input  logic        io_jtag_TRSTn,
  output logic        io_jtag_TDO,
  output logic        tdo_en,
  input  logic [31:0] user_capture_data,
  output logic        user_update_valid,
  output logic [31:0] user_update_data,
  output logic [3:0]  tap_state
);

  logic tck_rise_s;
  logic tck_fall_s;
  logic tms_s;
  logic tdi_s;
  logic trst_n_s;

  jtag_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clock       (clock),
    .reset       (reset),
    .tck         (io_jtag_TCK),
    .tms         (io_jtag_TMS),
    .tdi         (io_jtag_TDI),
    .trst_n      (io_jtag_TRSTn),
    .tck_rise    (tck_rise_s),
    .tck_fall    (tck_fall_s),
    .tms_sync    (tms_s),
    .tdi_sync    (tdi_s),
    .trst_n_sync (trst_n_s)
  );

  tap_state_t           state_r;
  tap_state_t           next_state_s;
  logic [IR_WIDTH-1:0]  ir_shift_r;
  logic [IR_WIDTH-1:0]  ir_active_r;
  logic [31:0]          dr_shift_r;
  logic [31:0]          dr_capture_s;
  logic                 user_sel_s;
  logic                 bypass_sel_s;
  logic                 tdo_r;
  logic                 tdo_en_r;
  logic                 upd_valid_r;
  logic [31:0]          upd_data_r;

  assign next_state_s = tap_next_state(state_r, tms_s);
  assign user_sel_s   = (ir_active_r == OP_USER);
  // Every opcode other than IDCODE and USER behaves as BYPASS.
  assign bypass_sel_s = (ir_active_r != OP_IDCODE) && !user_sel_s;
  assign dr_capture_s = (ir_active_r == OP_IDCODE) ? IDCODE :
                        user_sel_s                 ? user_capture_data : 32'h0000_0000;

  // TAP controller, shift/instruction registers and all outputs, stepped by synchronized TCK edges.
  always_ff @(posedge clock) begin
    upd_valid_r <= 1'b0;
    if (reset || !trst_n_s) begin
      // Reset wins over any TCK edge seen in the same cycle; a partial scan is dropped.
      state_r     <= TAP_RESET;
      ir_shift_r  <= 5'b00000;
      ir_active_r <= OP_IDCODE;
      dr_shift_r  <= 32'h0000_0000;
      tdo_r       <= 1'b0;
      tdo_en_r    <= 1'b0;
      upd_data_r  <= 32'h0000_0000;
    end else if (tck_rise_s) begin
      state_r  <= next_state_s;
      tdo_en_r <= is_shift_state(next_state_s);
      if (!is_shift_state(next_state_s)) begin
        tdo_r <= 1'b0;
      end
      // Capture/shift act on the rise that leaves the state, alongside the state change.
      case (state_r)
        TAP_CAPTURE_DR: dr_shift_r <= dr_capture_s;
        // BYPASS is a single-bit register, so TDI lands directly in bit 0.
        TAP_SHIFT_DR:   dr_shift_r <= bypass_sel_s ? {31'h0000_0000, tdi_s}
                                                   : {tdi_s, dr_shift_r[31:1]};
        TAP_CAPTURE_IR: ir_shift_r <= IR_CAPTURE;
        TAP_SHIFT_IR:   ir_shift_r <= {tdi_s, ir_shift_r[IR_WIDTH-1:1]};
        default: begin
        end
      endcase
      if (next_state_s == TAP_RESET) begin
        ir_active_r <= OP_IDCODE;
      end else if (next_state_s == TAP_UPDATE_IR) begin
        ir_active_r <= ir_shift_r;
      end
      if ((next_state_s == TAP_UPDATE_DR) && user_sel_s) begin
        upd_valid_r <= 1'b1;
        upd_data_r  <= dr_shift_r;
      end
    end else if (tck_fall_s) begin
      // TDO changes only on TCK falls, presenting the LSB of the active shift register.
      if (state_r == TAP_SHIFT_DR) begin
        tdo_r <= dr_shift_r[0];
      end else if (state_r == TAP_SHIFT_IR) begin
        tdo_r <= ir_shift_r[0];
      end else begin
        tdo_r <= 1'b0;
      end
    end
  end

  assign io_jtag_TDO       = tdo_r;
  assign tdo_en            = tdo_en_r;
  assign user_update_valid = upd_valid_r;
  assign user_update_data  = upd_data_r;
  assign tap_state         = state_r;

endmodule
